// File: rtl/alu_pkg.sv
// Shared opcode and FSM state definitions for the multi-cycle ALU.
package alu_pkg;

    localparam int unsigned OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 4'b0100,
        OP_SUB = 4'b0101,
        OP_OR  = 4'b0110,
        OP_AND = 4'b0111,
        OP_NOT = 4'b1000,
        OP_MUL = 4'b1001,
        OP_SHL = 4'b1010,
        OP_SHR = 4'b1011
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Sequential shift-add multiplier: one partial product per cycle, WIDTH cycles per multiply.
module alu_mul_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic               active;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            active <= 1'b0;
        end else if (start) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            cnt    <= CW'(WIDTH);
            active <= 1'b1;
        end else if (active) begin
            if (cnt != '0) begin
                if (mplier[0])
                    acc <= acc + mcand;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt - CW'(1);
            end else begin
                active <= 1'b0;
            end
        end
    end

    // done holds for the single cycle after the last accumulate step
    assign done    = active && (cnt == '0);
    assign product = acc;

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU with valid/ready handshake; MUL via sequential multiplier only when
// ALU_MUL_EN is defined, otherwise opcode 1001 is illegal and every op takes one cycle.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             zero
);
    state_e           state;
    state_e           state_next;
    logic             accept;
    logic             is_mul;
    logic [WIDTH-1:0] alu_result;
    logic             alu_overflow;
    logic [WIDTH:0]   sum;
    logic [31:0]      shamt;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;

`ifdef ALU_MUL_EN
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;

    assign is_mul = (op == OP_MUL);

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (accept && is_mul),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_product)
    );
`else
    assign is_mul = 1'b0;
`endif

    // Single-cycle ops evaluate straight from the inputs on the accepting edge
    always_comb begin
        alu_result   = '0;
        alu_overflow = 1'b0;
        sum          = {1'b0, a} + {1'b0, b};
        shamt        = 32'(b) % WIDTH;
        case (op)
            OP_ADD: begin
                alu_result   = sum[WIDTH-1:0];
                alu_overflow = sum[WIDTH];
            end
            OP_SUB: begin
                alu_result   = a - b;
                alu_overflow = (a < b);
            end
            OP_OR:  alu_result = a | b;
            OP_AND: alu_result = a & b;
            OP_NOT: alu_result = ~a;
            OP_SHL: alu_result = a << shamt;
            OP_SHR: alu_result = a >> shamt;
            default: ;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (in_valid) state_next = is_mul ? EXEC : DONE;
`ifdef ALU_MUL_EN
            EXEC: if (mul_done) state_next = DONE;
`endif
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            result   <= '0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else begin
            state <= state_next;
            if (accept && !is_mul) begin
                result   <= alu_result;
                overflow <= alu_overflow;
                zero     <= (alu_result == '0);
            end
`ifdef ALU_MUL_EN
            else if (state == EXEC && mul_done) begin
                result   <= mul_product[WIDTH-1:0];
                overflow <= |mul_product[2*WIDTH-1:WIDTH];
                zero     <= (mul_product[WIDTH-1:0] == '0);
            end
`endif
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle (WIDTH=8); follows ALU_MUL_EN for MUL expectations.
module tb_alu_multicycle;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   op = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         overflow;
    logic         zero;

    int total  = 0;
    int passed = 0;

`ifdef ALU_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    alu_multicycle #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    endtask

    // Reference model from the arithmetic rules; latency counted in cycles after accept
    task automatic model(input int o, input int av, input int bv,
                         output int r, output int ov, output int z, output int lat);
        int p;
        r = 0; ov = 0; lat = 1;
        case (o)
            4: begin p = av + bv; r = p % 256; ov = (p > 255); end
            5: begin r = (av - bv + 256) % 256; ov = (av < bv); end
            6: r = av | bv;
            7: r = av & bv;
            8: r = 255 - av;
            9: if (MUL_ON) begin p = av * bv; r = p % 256; ov = (p > 255); lat = W + 1; end
            10: r = (av * (1 << (bv % W))) % 256;
            11: r = av / (1 << (bv % W));
            default: ;
        endcase
        z = (r == 0);
    endtask

    task automatic run_op(input string tag, input int o, input int av, input int bv, input int hold);
        int er, eov, ez, elat, lat;
        model(o, av, bv, er, eov, ez, elat);
        @(negedge clk);
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        op = 4'(o); a = W'(av); b = W'(bv); in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op = 4'($urandom); a = W'($urandom); b = W'($urandom);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".latency"}, 32'(lat), 32'(elat));
        check({tag, ".result"}, 32'(result), 32'(er));
        check({tag, ".overflow"}, 32'(overflow), 32'(eov));
        check({tag, ".zero"}, 32'(zero), 32'(ez));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            check({tag, ".hold_result"}, 32'(result), 32'(er));
            check({tag, ".hold_ovf"}, 32'(overflow), 32'(eov));
            check({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        check({tag, ".release_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".release_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int ro, ra, rb;
        repeat (3) @(posedge clk);
        #1;
        check("reset.in_ready", 32'(in_ready), 32'd1);
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check("reset.result", 32'(result), 32'd0);
        check("reset.overflow", 32'(overflow), 32'd0);
        check("reset.zero", 32'(zero), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("add_200_100", 4, 200, 100, 0);
        run_op("sub_3_5", 5, 3, 5, 0);
        run_op("sub_5_5", 5, 5, 5, 0);
        run_op("mul_15_17", 9, 15, 17, 0);
        run_op("mul_16_16", 9, 16, 16, 0);
        run_op("mul_3_3", 9, 3, 3, 0);
        run_op("shl_81_9", 10, 8'h81, 9, 0);
        run_op("shr_81_3", 11, 8'h81, 3, 0);
        run_op("not_5a", 8, 8'h5A, 0, 0);
        run_op("illegal_0", 0, 12, 34, 0);
        run_op("or_hold5", 6, 8'h12, 8'h40, 5);

        // Reset while busy: EXEC cycle 4 for MUL, otherwise while holding DONE
        @(negedge clk);
        op = MUL_ON ? 4'd9 : 4'd4; a = 8'd200; b = 8'd100; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_busy.out_valid", 32'(out_valid), 32'd0);
        check("rst_busy.in_ready", 32'(in_ready), 32'd1);
        check("rst_busy.result", 32'(result), 32'd0);
        check("rst_busy.overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("and_after_rst", 7, 8'hF0, 8'h3C, 0);

        for (int n = 0; n < 60; n++) begin
            ro = int'($urandom_range(12, 2));
            ra = int'($urandom_range(255, 0));
            rb = int'($urandom_range(255, 0));
            run_op($sformatf("rand%0d_op%0d", n, ro), ro, ra, rb, n % 3);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand/result width in bits, legal range 2..32.
REQ-002 clk  input  1  sole clock, all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 in_valid  input  1  operation request present.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 op  input  4  opcode.
REQ-007 a  input  WIDTH  operand A (unsigned).
REQ-008 b  input  WIDTH  operand B (unsigned).
REQ-009 out_valid  output  1  result, overflow and zero are valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 result  output  WIDTH  operation result.
REQ-012 overflow  output  1  result not representable in WIDTH bits.
REQ-013 zero  output  1  result equals 0.

Function
REQ-014 Opcodes SHALL be: 0100 ADD, 0101 SUB, 0110 OR, 0111 AND, 1000 NOT A, 1001 MUL, 1010 SHL, 1011 SHR; all others are ILLEGAL.
REQ-015 FSM states SHALL be IDLE, EXEC and DONE; in_ready SHALL be 1 only in IDLE.
REQ-016 A request SHALL be accepted on a rising edge with in_valid=1 and in_ready=1; a, b and op are captured then and ignored afterwards.
REQ-017 Non-MUL ops SHALL go IDLE->DONE, with out_valid=1 one cycle after acceptance.
REQ-018 MUL SHALL go IDLE->EXEC, run shift-add for exactly WIDTH cycles, then go to DONE, with out_valid=1 WIDTH+1 cycles after acceptance.
REQ-019 In DONE, result, overflow and zero SHALL be held stable until an edge with out_ready=1; the FSM then returns to IDLE, so no new request is accepted on that same edge.
REQ-020 ADD: result=(a+b) mod 2^WIDTH; overflow=carry out.
REQ-021 SUB: result=(a-b) mod 2^WIDTH; overflow=1 when a<b.
REQ-022 OR, AND, NOT: bitwise; overflow=0.
REQ-023 MUL: result=low WIDTH bits of a*b; overflow=1 when any upper WIDTH bits are nonzero.
REQ-024 SHL and SHR: logical shift of a by b mod WIDTH; overflow=0.
REQ-025 ILLEGAL: result=0, overflow=0, zero=1.
REQ-026 zero SHALL be computed from the final registered result.
REQ-027 in_valid and out_ready SHALL be ignored in EXEC; out_ready SHALL be ignored outside DONE.

Reset
REQ-028 rst=1 SHALL immediately force state to IDLE, in_ready=1 and out_valid=0, and clear result, overflow, zero and all multiplier state, including mid-EXEC or mid-DONE.
REQ-029 After rst is deasserted, the first request SHALL be accepted on the first clk edge with in_valid=1.

Configuration
REQ-030 Macro ALU_MUL_EN defined: MUL SHALL behave per REQ-018 and REQ-023.
REQ-031 ALU_MUL_EN undefined: opcode 1001 SHALL be treated as ILLEGAL, the EXEC state and multiplier SHALL NOT be synthesised, and all ops SHALL complete in 1 cycle.

Structure
REQ-032 The package alu_pkg SHALL hold the opcode enum op_e (4-bit), the FSM state enum state_e and the opcode constants.
REQ-033 The sequential shift-add multiplier SHALL be a sub-module alu_mul_seq (start, operands in; done, 2*WIDTH product out), instantiated only under ALU_MUL_EN.

Verification (WIDTH=8)
REQ-034 ADD a=200 b=100 -> out_valid 1 cycle after accept, result=44, overflow=1, zero=0.
REQ-035 SUB a=3 b=5 -> result=254, overflow=1; SUB a=5 b=5 -> result=0, zero=1, overflow=0.
REQ-036 MUL a=15 b=17 -> out_valid exactly 9 cycles after accept, result=255, overflow=0; MUL a=16 b=16 -> result=0, overflow=1, zero=1.
REQ-037 Hold out_ready=0 for 5 cycles in DONE -> outputs stable and in_ready=0 throughout; out_ready=1 -> next cycle in_ready=1 and out_valid=0.
REQ-038 Assert rst during MUL EXEC cycle 4 -> out_valid=0 and in_ready=1 at once; a following AND a=0xF0 b=0x3C returns 0x30.
REQ-039 With ALU_MUL_EN undefined, MUL a=3 b=3 -> 1-cycle latency, result=0, zero=1; SHL a=0x81 b=9 -> result=0x02.
